// File: rtl/serdes_link_ctrl.sv
// SERDES link controller: TX framing into an external serializer and
// RX sync-byte hunt, alignment and byte delivery from a serial line.
module serdes_link_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         IDLE_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       par_en,
  output logic       ser_en,
  input  logic       ser_in,
  output logic       data_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       rx_relock,
  output logic       locked,
  output logic       rx_overrun
);

  // ---------------- TX path ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT, TX_GAP} tx_state_t;

  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);
  localparam bit         NO_GAP   = (IDLE_GAP == 0);

  tx_state_t  tx_state, tx_nxt;
  logic [2:0] sh_cnt;
  logic [3:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_byte  <= '0;
      sh_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      tx_state <= tx_nxt;
      if (tx_state == TX_IDLE && tx_valid) tx_byte <= tx_data;
      sh_cnt  <= (tx_state == TX_SHIFT) ? sh_cnt + 3'd1 : 3'd0;
      gap_cnt <= (tx_state == TX_GAP)   ? gap_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    tx_nxt   = tx_state;
    tx_ready = 1'b0;
    par_en   = 1'b0;
    ser_en   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) tx_nxt = TX_LOAD;
      end
      TX_LOAD: begin
        par_en = 1'b1;
        tx_nxt = TX_SHIFT;
      end
      TX_SHIFT: begin
        ser_en = 1'b1;
        if (sh_cnt == 3'd7) tx_nxt = NO_GAP ? TX_IDLE : TX_GAP;
      end
      TX_GAP: begin
        if (gap_cnt == GAP_LAST) tx_nxt = TX_IDLE;
      end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  // ---------------- RX path ----------------
  typedef enum logic {RX_HUNT, RX_LOCKED} rx_state_t;

  rx_state_t  rx_state, rx_nxt;
  logic [7:0] hunt_sr, rx_sr;
  logic [2:0] bit_cnt;
  logic [7:0] hunt_word, rx_word;
  logic       byte_done, byte_load;

  always_comb begin
    hunt_word = {hunt_sr[6:0], ser_in};
    rx_word   = {rx_sr[6:0], ser_in};
    byte_done = (rx_state == RX_LOCKED) && (bit_cnt == 3'd7) && !rx_relock;
    // Sync bytes seen while aligned only confirm lock; they never reach the consumer.
    byte_load = byte_done && (rx_word != SYNC_BYTE);
    rx_nxt    = rx_state;
    if (rx_relock)
      rx_nxt = RX_HUNT;
    else if (rx_state == RX_HUNT && hunt_word == SYNC_BYTE)
      rx_nxt = RX_LOCKED;
    locked  = (rx_state == RX_LOCKED);
    data_en = (rx_state == RX_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_HUNT;
      hunt_sr    <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_state <= rx_nxt;
      if (rx_relock) begin
        hunt_sr <= '0;
        rx_sr   <= '0;
        bit_cnt <= '0;
      end else if (rx_state == RX_HUNT) begin
        hunt_sr <= hunt_word;
        bit_cnt <= '0;
      end else begin
        rx_sr   <= rx_word;
        bit_cnt <= bit_cnt + 3'd1;
      end
      // A load coinciding with a consume keeps rx_valid high without overrun.
      if (byte_load) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serdes_link_ctrl.md
SERDES_LINK_CTRL -- requirements
Module: serdes_link_ctrl

Interface
REQ-001 Parameter: SYNC_BYTE, default 8'hA5, framing byte sent/hunted MSB-first.
REQ-002 Parameter: IDLE_GAP, default 2, idle cycles after each TX frame (0..15; 0 legal).
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: tx_data  in  8  byte offered by host.
REQ-006 Port: tx_valid  in  1  host byte valid.
REQ-007 Port: tx_ready  out  1  controller can accept byte.
REQ-008 Port: tx_byte  out  8  parallel byte to serializer (data_8b_in).
REQ-009 Port: par_en  out  1  serializer parallel-load strobe.
REQ-010 Port: ser_en  out  1  serializer shift enable.
REQ-011 Port: ser_in  in  1  received serial line, MSB-first.
REQ-012 Port: data_en  out  1  deserializer shift enable.
REQ-013 Port: rx_data  out  8  received payload byte.
REQ-014 Port: rx_valid  out  1  rx_data valid, held until consumed.
REQ-015 Port: rx_ready  in  1  consumer accepts rx_data.
REQ-016 Port: rx_relock  in  1  force return to sync hunt.
REQ-017 Port: locked  out  1  RX frame alignment achieved.
REQ-018 Port: rx_overrun  out  1  sticky: unconsumed byte overwritten.

Function
REQ-019 TX FSM states SHALL be IDLE, LOAD, SHIFT, GAP; tx_ready SHALL be 1 only in IDLE.
REQ-020 Handshake: tx_valid&tx_ready at cycle T SHALL latch tx_data into tx_byte and enter LOAD at T+1.
REQ-021 LOAD SHALL last 1 cycle with par_en=1, ser_en=0; then SHIFT.
REQ-022 SHIFT SHALL last exactly 8 cycles (3-bit counter 0..7) with ser_en=1, par_en=0; then GAP, or IDLE if IDLE_GAP=0.
REQ-023 GAP SHALL last IDLE_GAP cycles with ser_en=par_en=0; then IDLE.
REQ-024 tx_byte SHALL hold its latched value until the next accepted handshake; tx_valid outside IDLE SHALL be ignored.
REQ-025 Back-to-back TX: byte accepted at T, next earliest accept at T+10+IDLE_GAP.
REQ-026 RX states SHALL be HUNT and LOCKED; locked=1 iff LOCKED.
REQ-027 HUNT: each cycle hunt_sr <= {hunt_sr[6:0], ser_in}; when {hunt_sr[6:0], ser_in}==SYNC_BYTE, next state LOCKED with bit count 0.
REQ-028 data_en SHALL be 1 in every LOCKED cycle, 0 in HUNT.
REQ-029 LOCKED: each cycle shift ser_in into rx_sr MSB-first; on 8th bit, byte completes and next byte starts on the following cycle with no gap.
REQ-030 Completed byte equal to SYNC_BYTE SHALL be discarded (no rx_valid, lock retained).
REQ-031 Completed non-sync byte SHALL load rx_data and set rx_valid=1 on the next cycle.
REQ-032 rx_valid SHALL clear on the cycle after rx_valid&rx_ready, unless a new byte loads that same cycle (then stays 1, no overrun).
REQ-033 New byte loading while rx_valid=1 and rx_ready=0 SHALL overwrite rx_data and set rx_overrun=1 (sticky until rst).
REQ-034 rx_relock=1 in any state SHALL force HUNT next cycle, clear hunt_sr and bit count, discard partial byte; rx_valid/rx_data unaffected.
REQ-035 rx_relock and sync match in same cycle: rx_relock wins (HUNT).
REQ-036 TX and RX paths SHALL operate independently and concurrently.

Reset
REQ-037 rst=1 SHALL on next edge set: TX IDLE, tx_ready=1, tx_byte=0, par_en=0, ser_en=0; RX HUNT, hunt_sr=0, rx_sr=0, data_en=0, locked=0, rx_data=0, rx_valid=0, rx_overrun=0.
REQ-038 rst mid-frame SHALL abort the frame with no further par_en/ser_en pulses; rst overrides all inputs.

Verification
REQ-039 TX single: tx_data=8'h3C, tx_valid at T -> par_en=1 at T+1, tx_byte=8'h3C, ser_en=1 T+2..T+9, tx_ready=1 at T+12 (IDLE_GAP=2).
REQ-040 TX hold-off: tx_valid held high with 8'h11 then 8'h22 -> exactly one par_en per 12 cycles, tx_byte 8'h11 then 8'h22.
REQ-041 RX lock: drive 8'hA5 then 8'h5A MSB-first -> locked=1 after 8th sync bit, data_en=1, rx_valid=1 with rx_data=8'h5A one cycle after its 8th bit.
REQ-042 RX filter/overrun: locked, rx_ready=0, send 8'h01, 8'hA5, 8'h02 -> rx_data ends 8'h02, A5 never presented, rx_overrun=1.
REQ-043 Relock: rx_relock pulse mid-byte -> locked=0, data_en=0 next cycle; no rx_valid until new 8'hA5 seen.
REQ-044 Reset mid-operation: rst during SHIFT and LOCKED -> all outputs at REQ-037 values next cycle, tx_ready=1.
